// File: rtl/led_scroll_controller.sv
// Four-digit scrolling message controller: a 16-character buffer that is loaded
// while idle and then rotated through a four-character display window.
module led_scroll_controller #(
  parameter logic [23:0] SCROLL_TICKS = 24'd12500000,
  parameter logic [3:0]  BLANK        = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_data,
  output logic        wr_ready,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] disp_data,
  output logic        disp_update,
  output logic [4:0]  msg_len,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_PAUSE} state_t;

  localparam logic [15:0] BLANK_WIN = {4{BLANK}};
  localparam logic [23:0] LAST_TICK = SCROLL_TICKS - 24'd1;

  state_t      r_state, w_state_next;
  logic [3:0]  r_buf [16];
  logic [4:0]  r_len, w_len_next;
  logic [3:0]  r_p, w_p_next;
  logic [23:0] r_cnt, w_cnt_next;
  logic [15:0] r_disp, w_disp_next;
  logic        r_upd, w_upd_next;
  logic        r_wr_ready, w_wr_ready_next;
  logic        w_wr_fire;

  // Pointer advance: p < L always, so p+1 can only reach L, never exceed it.
  logic [4:0]  w_p_inc;
  logic [3:0]  w_p_adv;
  logic [3:0]  w_base;
  assign w_p_inc = {1'b0, r_p} + 5'd1;
  assign w_p_adv = (w_p_inc >= r_len) ? 4'd0 : w_p_inc[3:0];
  assign w_base  = (r_state == S_IDLE) ? 4'd0 : w_p_adv;

  // Each window slot is the previous slot plus one, folded once into 0..L-1.
  logic [4:0]  w_idx [4];
  logic [15:0] w_win;
  assign w_idx[0] = {1'b0, w_base};

  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_idx
      logic [4:0] w_sum;
      assign w_sum     = w_idx[gi-1] + 5'd1;
      assign w_idx[gi] = (w_sum >= r_len) ? (w_sum - r_len) : w_sum;
    end
    for (gi = 0; gi < 4; gi++) begin : g_win
      assign w_win[15-4*gi -: 4] = r_buf[w_idx[gi][3:0]];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_p_next     = r_p;
    w_cnt_next   = r_cnt;
    w_disp_next  = r_disp;
    w_upd_next   = 1'b0;
    w_wr_fire    = 1'b0;
    if (clear) begin
      w_state_next = S_IDLE;
      w_len_next   = 5'd0;
      w_p_next     = 4'd0;
      w_cnt_next   = 24'd0;
      w_disp_next  = BLANK_WIN;
      w_upd_next   = (r_disp != BLANK_WIN);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (r_len != 5'd0)) begin
            w_state_next = S_SCROLL;
            w_p_next     = 4'd0;
            w_cnt_next   = 24'd0;
            w_disp_next  = w_win;
            w_upd_next   = 1'b1;
          end else if (wr_en && r_wr_ready) begin
            w_wr_fire  = 1'b1;
            w_len_next = r_len + 5'd1;
          end
        end
        S_SCROLL: begin
          if (stop) begin
            w_state_next = S_PAUSE;
          end else if (r_cnt == LAST_TICK) begin
            w_cnt_next  = 24'd0;
            w_p_next    = w_p_adv;
            w_disp_next = w_win;
            w_upd_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 24'd1;
          end
        end
        S_PAUSE: begin
          if (start) begin
            w_state_next = S_SCROLL;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
    w_wr_ready_next = (w_state_next == S_IDLE) && (w_len_next < 5'd16);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= 5'd0;
      r_p        <= 4'd0;
      r_cnt      <= 24'd0;
      r_disp     <= BLANK_WIN;
      r_upd      <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_len      <= w_len_next;
      r_p        <= w_p_next;
      r_cnt      <= w_cnt_next;
      r_disp     <= w_disp_next;
      r_upd      <= w_upd_next;
      r_wr_ready <= w_wr_ready_next;
    end
  end

  // Buffer contents survive reset; only the length is forgotten.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_buf[r_len[3:0]] <= wr_data;
    end
  end

  assign wr_ready    = r_wr_ready;
  assign disp_data   = r_disp;
  assign disp_update = r_upd;
  assign msg_len     = r_len;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_led_scroll_controller.sv
// Directed and randomized checks of the scroll controller against a cycle-level
// message/pointer model built from the behavioural rules.
module tb_led_scroll_controller;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_data = 4'd0;
  logic        wr_ready;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] disp_data;
  logic        disp_update;
  logic [4:0]  msg_len;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  led_scroll_controller #(.SCROLL_TICKS(24'd4), .BLANK(4'hF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .stop(stop), .clear(clear), .disp_data(disp_data),
    .disp_update(disp_update), .msg_len(msg_len), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: message contents, length, pointer and elapsed scroll cycles.
  logic [3:0]  m_mem [16];
  int          m_len, m_p, m_cnt;
  bit          m_busy, m_paused, m_upd, m_wr_ready;
  logic [15:0] m_disp;

  function automatic logic [15:0] window(input int p);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[15-4*k -: 4] = m_mem[(p + k) % m_len];
    return r;
  endfunction

  task automatic model_reset();
    m_len = 0; m_p = 0; m_cnt = 0; m_busy = 0; m_paused = 0;
    m_upd = 0; m_wr_ready = 0; m_disp = 16'hFFFF;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("disp_data", disp_data, m_disp);
    chk("disp_update", {15'd0, disp_update}, {15'd0, m_upd});
    chk("msg_len", {11'd0, msg_len}, 16'(m_len));
    chk("busy", {15'd0, busy}, {15'd0, m_busy});
    chk("wr_ready", {15'd0, wr_ready}, {15'd0, m_wr_ready});
  endtask

  task automatic tick(input logic s, input logic st, input logic c, input logic w, input logic [3:0] d);
    logic [15:0] prev;
    start = s; stop = st; clear = c; wr_en = w; wr_data = d;
    @(posedge clk);
    prev = m_disp;
    m_upd = 0;
    if (c) begin
      m_busy = 0; m_paused = 0; m_len = 0; m_p = 0; m_cnt = 0;
      m_disp = 16'hFFFF;
      m_upd = (prev != 16'hFFFF);
    end else if (!m_busy) begin
      if (s && m_len >= 1) begin
        m_busy = 1; m_paused = 0; m_p = 0; m_cnt = 0;
        m_disp = window(0); m_upd = 1;
      end else if (w && m_wr_ready) begin
        m_mem[m_len] = d;
        m_len++;
      end
    end else if (!m_paused) begin
      if (st) m_paused = 1;
      else begin
        m_cnt++;
        if (m_cnt == T) begin
          m_cnt = 0;
          m_p = (m_p + 1) % m_len;
          m_disp = window(m_p);
          m_upd = 1;
        end
      end
    end else if (s) begin
      m_paused = 0;
    end
    m_wr_ready = !m_busy && (m_len < 16);
    #1;
    check_all();
    if (s || st || c || w)
      $display("t=%0t start=%b stop=%b clear=%b wr=%b data=%h -> len=%0d disp=%h upd=%b busy=%b",
               $time, s, st, c, w, d, msg_len, disp_data, disp_update, busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 4'd0);
  endtask

  logic [15:0] exp_seq [5];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    tick(0, 0, 0, 0, 4'd0);
    chk("wr_ready_after_reset", {15'd0, wr_ready}, 16'd1);

    // Five-character load and scroll with wrap-around
    for (int i = 1; i <= 5; i++) tick(0, 0, 0, 1, 4'(i));
    tick(1, 0, 0, 0, 4'd0);
    chk("load_window", disp_data, 16'h1234);
    chk("load_pulse", {15'd0, disp_update}, 16'd1);
    exp_seq[0] = 16'h2345; exp_seq[1] = 16'h3451; exp_seq[2] = 16'h4512;
    exp_seq[3] = 16'h5123; exp_seq[4] = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      idle(T - 1);
      tick(0, 0, 0, 0, 4'd0);
      chk("scroll_window", disp_data, exp_seq[k]);
      chk("scroll_pulse", {15'd0, disp_update}, 16'd1);
    end

    // Pause two cycles into a step, hold, then resume
    idle(2);
    tick(0, 1, 0, 0, 4'd0);
    idle(10);
    chk("pause_frozen", disp_data, 16'h1234);
    tick(1, 0, 0, 0, 4'd0);
    chk("resume_no_pulse", {15'd0, disp_update}, 16'd0);
    tick(0, 0, 0, 0, 4'd0);
    chk("resume_early", {15'd0, disp_update}, 16'd0);
    tick(0, 0, 0, 0, 4'd0);
    chk("resume_step", disp_data, 16'h2345);
    chk("resume_step_pulse", {15'd0, disp_update}, 16'd1);

    // All commands together while scrolling: clear wins
    tick(1, 1, 1, 1, 4'd7);
    chk("prio_len", {11'd0, msg_len}, 16'd0);
    chk("prio_disp", disp_data, 16'hFFFF);
    chk("prio_busy", {15'd0, busy}, 16'd0);
    idle(1);

    // Single-character message
    tick(0, 0, 0, 1, 4'hA);
    tick(1, 0, 0, 0, 4'd0);
    chk("short_window", disp_data, 16'hAAAA);
    for (int k = 0; k < 3; k++) begin
      idle(T - 1);
      tick(0, 0, 0, 0, 4'd0);
      chk("short_pulse", {15'd0, disp_update}, 16'd1);
      chk("short_window_hold", disp_data, 16'hAAAA);
    end
    tick(0, 0, 1, 0, 4'd0);

    // Seventeen writes: the last is dropped
    for (int i = 0; i < 17; i++) begin
      tick(0, 0, 0, 1, 4'($urandom_range(0, 15)));
      if (i == 15) chk("full_ready_low", {15'd0, wr_ready}, 16'd0);
    end
    chk("full_len", {11'd0, msg_len}, 16'd16);
    tick(1, 0, 0, 0, 4'd0);
    idle(16 * T + 6);

    // Random messages with random stop/start/clear traffic
    for (int it = 0; it < 20; it++) begin
      int len;
      tick(0, 0, 1, 0, 4'd0);
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) tick(0, 0, 0, 1, 4'($urandom_range(0, 15)));
      tick(1, 0, 0, 0, 4'd0);
      for (int c = 0; c < 60; c++)
        tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
    end

    // Asynchronous reset between clock edges while scrolling
    tick(0, 0, 1, 0, 4'd0);
    for (int i = 1; i <= 5; i++) tick(0, 0, 0, 1, 4'(i));
    tick(1, 0, 0, 0, 4'd0);
    idle(6);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_disp", disp_data, 16'hFFFF);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    tick(1, 0, 0, 0, 4'd0);
    chk("start_after_reset_ignored", {15'd0, busy}, 16'd0);
    chk("wr_ready_rises", {15'd0, wr_ready}, 16'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_scroll_controller.md
LED_SCROLL_CONTROLLER -- requirements
Module: led_scroll_controller

Interface
REQ-001 SHALL have parameter SCROLL_TICKS, default 24'd12500000, clk cycles per scroll step (legal range 2..2^24-1).
REQ-002 SHALL have parameter BLANK, default 4'hF, character code driven when no message is loaded.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write one character into the message buffer.
REQ-006 SHALL have port wr_data  input  4  character code to write.
REQ-007 SHALL have port wr_ready  output  1  buffer accepts a write this cycle.
REQ-008 SHALL have port start  input  1  begin or resume scrolling.
REQ-009 SHALL have port stop  input  1  pause scrolling.
REQ-010 SHALL have port clear  input  1  empty the buffer and return to IDLE.
REQ-011 SHALL have port disp_data  output  16  four-character window; [15:12] is leftmost digit (an3), [3:0] is rightmost (an0).
REQ-012 SHALL have port disp_update  output  1  one-cycle pulse when disp_data changes.
REQ-013 SHALL have port msg_len  output  5  number of stored characters, 0..16.
REQ-014 SHALL have port busy  output  1  high in SCROLL or PAUSE.

Function
REQ-015 SHALL hold a 16-entry x 4-bit message buffer with write index equal to msg_len.
REQ-016 SHALL implement states IDLE, SCROLL, PAUSE, all outputs registered.
REQ-017 SHALL assert wr_ready only in IDLE with msg_len<16 and clear low.
REQ-018 SHALL, on wr_en with wr_ready, store wr_data at buf[msg_len] and increment msg_len next cycle; wr_en without wr_ready SHALL be ignored (no state change).
REQ-019 SHALL, on start in IDLE with msg_len>=1, set pointer p=0, tick counter=0, go to SCROLL, load window and pulse disp_update on the next cycle; start with msg_len=0 SHALL be ignored.
REQ-020 SHALL form the window as {buf[p], buf[(p+1) mod L], buf[(p+2) mod L], buf[(p+3) mod L]}, L=msg_len, modulo computed without a divider (conditional subtract; valid for L<4, e.g. L=1 repeats one char four times).
REQ-021 SHALL, in SCROLL, increment tick counter every cycle; on count SCROLL_TICKS-1 reset counter to 0, advance p to (p+1) mod L, and update disp_data with one-cycle disp_update pulse on the following cycle.
REQ-022 SHALL, on stop in SCROLL, go to PAUSE freezing p, tick counter and disp_data; no disp_update in PAUSE.
REQ-023 SHALL, on start in PAUSE, return to SCROLL continuing from the frozen tick count (no window reload, no pulse).
REQ-024 SHALL, on clear in any state, next cycle: state IDLE, msg_len=0, p=0, counter=0, disp_data={4{BLANK}}, disp_update one-cycle pulse only if disp_data was not already all BLANK.
REQ-025 SHALL prioritise simultaneous inputs: clear > stop > start > wr_en.
REQ-026 SHALL ignore start in SCROLL and stop in IDLE/PAUSE.
REQ-027 SHALL keep p in 0..L-1 at all times; wrap from L-1 to 0 without glitch or skipped character.
REQ-028 SHALL drive disp_data={4{BLANK}} in IDLE; buffer writes in IDLE SHALL NOT alter disp_data.

Reset
REQ-029 SHALL, while reset is high, asynchronously force state IDLE, msg_len=0, p=0, counter=0, disp_data={4{BLANK}}, disp_update=0, busy=0, wr_ready=0; wr_ready rises one cycle after reset deasserts.
REQ-030 SHALL abort any scroll on reset mid-operation; buffer contents need not be cleared, only msg_len.

Verification (bench uses SCROLL_TICKS=4)
REQ-031 SHALL test load/scroll: write 1,2,3,4,5, start -> disp_data 16'h1234 with pulse, then 16'h2345, 16'h3451, 16'h4512, 16'h5123, 16'h1234 every 4 cycles.
REQ-032 SHALL test short message: write A only, start -> disp_data 16'hAAAA, pulse every 4 cycles, value unchanged.
REQ-033 SHALL test full buffer: 17 writes in IDLE -> msg_len=16, wr_ready low after 16th, 17th ignored.
REQ-034 SHALL test pause/resume: stop 2 cycles after a step, hold 10 cycles -> no pulse, disp_data frozen; start -> next step exactly 2 cycles after resume.
REQ-035 SHALL test priority: clear+stop+start+wr_en same cycle in SCROLL -> IDLE, msg_len=0, disp_data 16'hFFFF, no write.
REQ-036 SHALL test async reset mid-scroll: reset asserted between clk edges -> outputs at reset values immediately, busy=0; start without rewrite ignored.
